// File: rtl/alu_bist_pkg.sv
// Shared types for the ALU built-in self-test vector engine: FSM states,
// the packed vector layout and helpers that locate each field in a vector word.
package alu_bist_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_FW    = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_e;

  // Vector word at the default widths, f in the MSBs and zexp in bit 0.
  typedef struct packed {
    logic [ALU_FW-1:0]    f;
    logic [ALU_WIDTH-1:0] a;
    logic [ALU_WIDTH-1:0] b;
    logic [ALU_WIDTH-1:0] yexp;
    logic                 zexp;
  } alu_vec_t;

  localparam int ZEXP_POS = 0;
  localparam int YEXP_LSB = 1;

  function automatic int b_lsb(input int width);
    return YEXP_LSB + width;
  endfunction

  function automatic int a_lsb(input int width);
    return YEXP_LSB + 2 * width;
  endfunction

  function automatic int f_lsb(input int width);
    return YEXP_LSB + 3 * width;
  endfunction

endpackage

// File: rtl/alu_vector_unpack.sv
// Combinational split of a packed {f,a,b,yexp,zexp} vector word into fields.
module alu_vector_unpack
  import alu_bist_pkg::*;
#(
  parameter  int WIDTH = ALU_WIDTH,
  parameter  int FW    = ALU_FW,
  localparam int VW    = FW + 3 * WIDTH + 1
) (
  input  logic [VW-1:0]    vec_i,
  output logic [FW-1:0]    f_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] yexp_o,
  output logic             zexp_o
);

  localparam int F_LSB = f_lsb(WIDTH);
  localparam int A_LSB = a_lsb(WIDTH);
  localparam int B_LSB = b_lsb(WIDTH);

  assign f_o    = vec_i[F_LSB +: FW];
  assign a_o    = vec_i[A_LSB +: WIDTH];
  assign b_o    = vec_i[B_LSB +: WIDTH];
  assign yexp_o = vec_i[YEXP_LSB +: WIDTH];
  assign zexp_o = vec_i[ZEXP_POS];

endmodule

// File: rtl/alu_vector_checker.sv
// ALU self-test engine: fetches vectors from a synchronous ROM, drives them into
// an ALU over a req/rsp handshake and reports mismatches, timeouts and first failure.
module alu_vector_checker
  import alu_bist_pkg::*;
#(
  parameter  int WIDTH   = ALU_WIDTH,
  parameter  int FW      = ALU_FW,
  parameter  int AW      = 10,
  parameter  int TIMEOUT = 16,
  localparam int VW      = FW + 3 * WIDTH + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AW:0]      num_vectors,
  input  logic             stop_on_err,
  output logic             vec_rd_en,
  output logic [AW-1:0]    vec_addr,
  input  logic [VW-1:0]    vec_data,
  output logic             dut_req,
  output logic [FW-1:0]    dut_f,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  input  logic             dut_rsp,
  input  logic [WIDTH-1:0] dut_y,
  input  logic             dut_zero,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [AW:0]      err_count,
  output logic [AW:0]      vec_count,
  output logic             timeout_flag,
  output logic [AW-1:0]    fail_index,
  output logic [WIDTH-1:0] fail_y
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [AW:0]      num_q, num_d;
  logic             soe_q, soe_d;
  logic [VW-1:0]    vec_q, vec_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             z_q, z_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [AW:0]      err_q, err_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             tout_q, tout_d;
  logic [AW-1:0]    fidx_q, fidx_d;
  logic [WIDTH-1:0] fy_q, fy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] yexp;
  logic             zexp;
  logic [AW:0]      err_sat;
  logic [AW:0]      cnt_inc;
  logic             first_fail;
  logic             mismatch;

  alu_vector_unpack #(
    .WIDTH (WIDTH),
    .FW    (FW)
  ) u_unpack (
    .vec_i  (vec_q),
    .f_o    (dut_f),
    .a_o    (dut_a),
    .b_o    (dut_b),
    .yexp_o (yexp),
    .zexp_o (zexp)
  );

  assign err_sat    = (&err_q) ? err_q : err_q + 1'b1;
  assign cnt_inc    = cnt_q + 1'b1;
  assign first_fail = (err_q == '0);
  assign mismatch   = (y_q != yexp) || (z_q != zexp);

  // NOTE: every _d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    soe_d   = soe_q;
    vec_d   = vec_q;
    y_d     = y_q;
    z_d     = z_q;
    tcnt_d  = tcnt_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    tout_d  = tout_q;
    fidx_d  = fidx_q;
    fy_d    = fy_q;
    done_d  = done_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          num_d  = num_vectors;
          soe_d  = stop_on_err;
          err_d  = '0;
          cnt_d  = '0;
          tout_d = 1'b0;
          fidx_d = '0;
          fy_d   = '0;
          if (num_vectors == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FETCH;
            done_d  = 1'b0;
          end
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        vec_d   = vec_data;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        tcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dut_rsp) begin
          y_d     = dut_y;
          z_d     = dut_zero;
          state_d = S_CHECK;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          // A silent ALU always ends the run, whatever stop_on_err says.
          tout_d  = 1'b1;
          err_d   = err_sat;
          if (first_fail) fidx_d = cnt_q[AW-1:0];
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        cnt_d = cnt_inc;
        if (mismatch) begin
          err_d = err_sat;
          if (first_fail) begin
            fidx_d = cnt_q[AW-1:0];
            fy_d   = y_q;
          end
        end
        if ((cnt_inc == num_q) || (mismatch && soe_q)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: synchronous active-low reset; state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      soe_q   <= 1'b0;
      vec_q   <= '0;
      y_q     <= '0;
      z_q     <= 1'b0;
      tcnt_q  <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      tout_q  <= 1'b0;
      fidx_q  <= '0;
      fy_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      soe_q   <= soe_d;
      vec_q   <= vec_d;
      y_q     <= y_d;
      z_q     <= z_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
      fidx_q  <= fidx_d;
      fy_q    <= fy_d;
      done_q  <= done_d;
    end
  end

  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done         = done_q;
  assign pass         = done_q && (err_q == '0) && !tout_q;
  assign vec_rd_en    = (state_q == S_FETCH);
  assign vec_addr     = (state_q == S_FETCH) ? cnt_q[AW-1:0] : '0;
  assign dut_req      = (state_q == S_ISSUE);
  assign err_count    = err_q;
  assign vec_count    = cnt_q;
  assign timeout_flag = tout_q;
  assign fail_index   = fidx_q;
  assign fail_y       = fy_q;

endmodule
